hdmi_video_source: RTL and testbench

- Parametrised successor to the fixed timing generator and solid-colour data path in the HDMI top.
- Generates video timing: VDE, plus CD = {vsync, hsync}.
- Generates 8-bit R/G/B pixel data from a selectable test pattern.
- Outputs feed the three TMDS_encoder instances directly; all outputs are registered and cycle-aligned.

---
 rtl/hdmi_video_pkg.sv | 43 ++++
 rtl/hdmi_timing_counter.sv | 72 +++++++
 rtl/hdmi_video_source.sv | 155 +++++++++++++++
 tb/tb_hdmi_video_source.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_video_pkg.sv
// Shared definitions for the HDMI video source: pattern modes, colour-bar palette
// and timing presets for the common CEA modes.
package hdmi_video_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_GRAD    = 2'd3
    } mode_e;

    localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
    localparam logic [23:0] RGB_BLACK = 24'h000000;

    // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][23:0] BAR_RGB = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_HS_POL   = 0;
    localparam int VGA_VS_POL   = 0;

    localparam int HD720_H_ACTIVE = 1280;
    localparam int HD720_H_FP     = 110;
    localparam int HD720_H_SYNC   = 40;
    localparam int HD720_H_BP     = 220;
    localparam int HD720_V_ACTIVE = 720;
    localparam int HD720_V_FP     = 5;
    localparam int HD720_V_SYNC   = 5;
    localparam int HD720_V_BP     = 20;
    localparam int HD720_HS_POL   = 1;
    localparam int HD720_VS_POL   = 1;

endpackage

// File: rtl/hdmi_timing_counter.sv
// Horizontal/vertical raster counters with active-region flag and raw (active-high)
// sync strobes; all outputs are decoded from the current counter state.
module hdmi_timing_counter #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          srst,
    output logic [CW-1:0] hcnt,
    output logic [CW-1:0] vcnt,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          line_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    // Colour bars need at least one pixel per bar and the gradient uses 8 counter bits.
    if (H_ACTIVE < 8 || V_ACTIVE < 1 || CW < 8 ||
        H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_params
        $fatal(1, "hdmi_timing_counter: degenerate timing parameters");
    end

    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;

    always_comb begin
        line_end = (hcnt_q == H_LAST);
        hcnt_d   = line_end ? '0 : hcnt_q + 1'b1;
        vcnt_d   = vcnt_q;
        if (line_end) begin
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hcnt   = hcnt_q;
    assign vcnt   = vcnt_q;
    assign active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    assign hsync  = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
    assign vsync  = (vcnt_q >= VS_START) && (vcnt_q < VS_END);

endmodule

// File: rtl/hdmi_video_source.sv
// Video timing plus test-pattern generator feeding the TMDS encoders; every output is
// registered one pixclk after counter state. Optional white frame border: VIDEO_BORDER_EN.
module hdmi_video_source
    import hdmi_video_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 12
) (
    input  logic          pixclk,
    input  logic          reset,
    input  logic [1:0]    mode,
    input  logic [23:0]   solid_rgb,
    output logic          VDE,
    output logic [1:0]    CD,
    output logic [7:0]    R_data,
    output logic [7:0]    G_data,
    output logic [7:0]    B_data,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);
    localparam logic [CW-1:0] BW_LAST = CW'(H_ACTIVE / 8 - 1);
`ifdef VIDEO_BORDER_EN
    localparam logic [CW-1:0] X_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(V_ACTIVE - 1);
`endif

    logic [CW-1:0] hcnt, vcnt;
    logic          active, hsync_raw, vsync_raw, line_end;

    hdmi_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CW       (CW)
    ) u_timing (
        .clk      (pixclk),
        .srst     (reset),
        .hcnt     (hcnt),
        .vcnt     (vcnt),
        .active   (active),
        .hsync    (hsync_raw),
        .vsync    (vsync_raw),
        .line_end (line_end)
    );

    mode_e         mode_q, mode_d;
    logic [23:0]   solid_q, solid_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [CW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic          vde_q, vde_d;
    logic [1:0]    cd_q, cd_d;
    logic [23:0]   rgb_q, rgb_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          fs_q, fs_d;
    logic [23:0]   pattern;
    logic          frame_first;

    always_comb begin
        // The (0,0) pixel already belongs to the new frame, so it uses the freshly
        // sampled controls and the incremented frame count.
        frame_first = (hcnt == '0) && (vcnt == '0);
        mode_d      = frame_first ? mode_e'(mode) : mode_q;
        solid_d     = frame_first ? solid_rgb : solid_q;
        frame_cnt_d = frame_first ? frame_cnt_q + 16'd1 : frame_cnt_q;

        // Bar position tracks hcnt+1; bar 7 keeps counting so it absorbs the remainder.
        bar_cnt_d = bar_cnt_q + 1'b1;
        bar_idx_d = bar_idx_q;
        if (line_end) begin
            bar_cnt_d = '0;
            bar_idx_d = 3'd0;
        end else if (bar_cnt_q == BW_LAST && bar_idx_q != 3'd7) begin
            bar_cnt_d = '0;
            bar_idx_d = bar_idx_q + 3'd1;
        end

        case (mode_d)
            MODE_SOLID:   pattern = solid_d;
            MODE_BARS:    pattern = BAR_RGB[bar_idx_q];
            MODE_CHECKER: pattern = (hcnt[5] ^ vcnt[5]) ? RGB_WHITE : RGB_BLACK;
            default:      pattern = {hcnt[7:0], vcnt[7:0], frame_cnt_d[7:0]};
        endcase
`ifdef VIDEO_BORDER_EN
        if (hcnt == '0 || hcnt == X_LAST || vcnt == '0 || vcnt == Y_LAST) begin
            pattern = RGB_WHITE;
        end
`endif

        vde_d = active;
        rgb_d = active ? pattern : RGB_BLACK;
        cd_d  = {vsync_raw ? VS_ON : ~VS_ON, hsync_raw ? HS_ON : ~HS_ON};
        x_d   = active ? hcnt : x_q;
        y_d   = active ? vcnt : y_q;
        fs_d  = frame_first;
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            mode_q      <= MODE_SOLID;
            solid_q     <= '0;
            frame_cnt_q <= '0;
            bar_cnt_q   <= '0;
            bar_idx_q   <= 3'd0;
            vde_q       <= 1'b0;
            cd_q        <= {~VS_ON, ~HS_ON};
            rgb_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            fs_q        <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            solid_q     <= solid_d;
            frame_cnt_q <= frame_cnt_d;
            bar_cnt_q   <= bar_cnt_d;
            bar_idx_q   <= bar_idx_d;
            vde_q       <= vde_d;
            cd_q        <= cd_d;
            rgb_q       <= rgb_d;
            x_q         <= x_d;
            y_q         <= y_d;
            fs_q        <= fs_d;
        end
    end

    assign VDE         = vde_q;
    assign CD          = cd_q;
    assign R_data      = rgb_q[23:16];
    assign G_data      = rgb_q[15:8];
    assign B_data      = rgb_q[7:0];
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = fs_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_hdmi_video_source.sv
// Bench for hdmi_video_source on a tiny 24x12 raster: a per-cycle reference model feeds a
// scoreboard queue, a vector table spot-checks pattern pixels, plus hand-written corner cases.
module tb_hdmi_video_source;

    localparam int CW = 12;
    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 8,  VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;

    logic          pixclk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic [23:0]   solid_rgb = 24'h0;
    logic          VDE;
    logic [1:0]    CD;
    logic [7:0]    R_data, G_data, B_data;
    logic [CW-1:0] x, y;
    logic          frame_start;
    logic [15:0]   frame_cnt;

    hdmi_video_source #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HS_POL(0), .VS_POL(0), .CW(CW)
    ) dut (
        .pixclk      (pixclk),
        .reset       (reset),
        .mode        (mode),
        .solid_rgb   (solid_rgb),
        .VDE         (VDE),
        .CD          (CD),
        .R_data      (R_data),
        .G_data      (G_data),
        .B_data      (B_data),
        .x           (x),
        .y           (y),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    always #5 pixclk = ~pixclk;

    typedef struct packed {
        logic          vde;
        logic [1:0]    cd;
        logic [23:0]   rgb;
        logic [CW-1:0] px;
        logic [CW-1:0] py;
        logic          fs;
        logic [15:0]   fcnt;
    } out_t;

    typedef struct {
        logic [1:0]  mode;
        logic [23:0] solid;
        int          px;
        int          py;
        logic [23:0] rgb;
    } vec_t;

    out_t exp_q[$];
    vec_t vecs[15];
    int   n_tests = 0;
    int   n_fail  = 0;

    int          m_h = 0, m_v = 0;
    logic [1:0]  m_mode = 2'd0;
    logic [23:0] m_solid = 24'h0;
    logic [15:0] m_fcnt = 16'h0;
    logic [CW-1:0] m_x = '0, m_y = '0;

    function automatic logic [23:0] ref_pixel(logic [1:0] md, logic [23:0] sol,
                                              int h, int v, logic [15:0] fc);
        logic [23:0] c;
        int bar;
        case (md)
            2'd0: c = sol;
            2'd1: begin
                bar = h / (HA / 8);
                if (bar > 7) bar = 7;
                case (bar)
                    0: c = 24'hFFFFFF;
                    1: c = 24'hFFFF00;
                    2: c = 24'h00FFFF;
                    3: c = 24'h00FF00;
                    4: c = 24'hFF00FF;
                    5: c = 24'hFF0000;
                    6: c = 24'h0000FF;
                    default: c = 24'h000000;
                endcase
            end
            2'd2: c = (((h / 32) + (v / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
            default: c = {h[7:0], v[7:0], fc[7:0]};
        endcase
`ifdef VIDEO_BORDER_EN
        if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) c = 24'hFFFFFF;
`endif
        return c;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One pixel clock: predict the registered outputs, advance, then compare.
    task automatic tick();
        out_t e, a;
        bit   act;
        int   h0, v0;
        h0 = m_h;
        v0 = m_v;
        if (reset) begin
            e = '{vde: 1'b0, cd: 2'b11, rgb: 24'h0, px: '0, py: '0, fs: 1'b0, fcnt: 16'h0};
            m_h = 0; m_v = 0; m_mode = 2'd0; m_solid = 24'h0; m_fcnt = 16'h0;
            m_x = '0; m_y = '0;
        end else begin
            if (m_h == 0 && m_v == 0) begin
                m_mode  = mode;
                m_solid = solid_rgb;
                m_fcnt  = m_fcnt + 16'd1;
            end
            act = (m_h < HA) && (m_v < VA);
            if (act) begin
                m_x = CW'(m_h);
                m_y = CW'(m_v);
            end
            e.vde  = act;
            e.cd   = {!(m_v >= VA + VFP && m_v < VA + VFP + VS),
                      !(m_h >= HA + HFP && m_h < HA + HFP + HS)};
            e.rgb  = act ? ref_pixel(m_mode, m_solid, m_h, m_v, m_fcnt) : 24'h0;
            e.px   = m_x;
            e.py   = m_y;
            e.fs   = (m_h == 0 && m_v == 0);
            e.fcnt = m_fcnt;
            m_h = m_h + 1;
            if (m_h == HT) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end
        end
        exp_q.push_back(e);
        @(posedge pixclk);
        #1;
        a = {VDE, CD, R_data, G_data, B_data, x, y, frame_start, frame_cnt};
        e = exp_q.pop_front();
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL scoreboard h=%0d v=%0d: got vde=%b cd=%b rgb=%h x=%0d y=%0d fs=%b fc=%0d, expected vde=%b cd=%b rgb=%h x=%0d y=%0d fs=%b fc=%0d",
                     h0, v0, a.vde, a.cd, a.rgb, a.px, a.py, a.fs, a.fcnt,
                     e.vde, e.cd, e.rgb, e.px, e.py, e.fs, e.fcnt);
        end
    endtask

    task automatic wait_frame_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            tick();
            ok = (frame_start === 1'b1);
        end
    endtask

    task automatic wait_pixel(input int px, input int py, output bit ok);
        ok = (VDE === 1'b1) && (x == CW'(px)) && (y == CW'(py));
        for (int i = 0; i < 400 && !ok; i++) begin
            tick();
            ok = (VDE === 1'b1) && (x == CW'(px)) && (y == CW'(py));
        end
    endtask

    initial begin
        bit ok;
        int fs_idx, period, vde_n, hs_n, vs_n;
        logic [23:0] want;

        vecs[0]  = '{2'd1, 24'h0, 0, 0, 24'hFFFFFF};
        vecs[1]  = '{2'd1, 24'h0, 1, 0, 24'hFFFFFF};
        vecs[2]  = '{2'd1, 24'h0, 2, 0, 24'hFFFF00};
        vecs[3]  = '{2'd1, 24'h0, 5, 3, 24'h00FFFF};
        vecs[4]  = '{2'd1, 24'h0, 7, 2, 24'h00FF00};
        vecs[5]  = '{2'd1, 24'h0, 8, 1, 24'hFF00FF};
        vecs[6]  = '{2'd1, 24'h0, 11, 6, 24'hFF0000};
        vecs[7]  = '{2'd1, 24'h0, 12, 5, 24'h0000FF};
        vecs[8]  = '{2'd1, 24'h0, 14, 7, 24'h000000};
        vecs[9]  = '{2'd1, 24'h0, 15, 4, 24'h000000};
        vecs[10] = '{2'd0, 24'h123456, 5, 5, 24'h123456};
        vecs[11] = '{2'd2, 24'h0, 9, 3, 24'h000000};
        vecs[12] = '{2'd0, 24'h102030, 1, 1, 24'h102030};
        vecs[13] = '{2'd0, 24'h102030, 0, 0, 24'h102030};
        vecs[14] = '{2'd0, 24'h102030, 15, 7, 24'h102030};

        #1;
        for (int i = 0; i < 5; i++) tick();
        check("reset_vde", 32'(VDE), 32'd0);
        check("reset_cd", 32'(CD), 32'd3);
        check("reset_rgb", {8'h0, R_data, G_data, B_data}, 32'd0);
        check("reset_fcnt", 32'(frame_cnt), 32'd0);

        // Counters sit at (0,0) in the cycle after release; its outputs show one edge later.
        reset = 1'b0;
        tick();
        check("first_fs", 32'(frame_start), 32'd1);
        check("first_vde", 32'(VDE), 32'd1);
        check("first_fcnt", 32'(frame_cnt), 32'd1);

        fs_idx = 0; vde_n = 0; hs_n = 0; vs_n = 0;
        for (int i = 1; i <= 2 * HT * VT; i++) begin
            tick();
            vde_n += int'(VDE);
            hs_n  += int'(!CD[0]);
            vs_n  += int'(!CD[1]);
            if (frame_start) begin
                period = i - fs_idx;
                fs_idx = i;
                check("frame_period", 32'(period), 32'd288);
            end
        end
        check("frame_pulses_seen", 32'(fs_idx), 32'd576);
        check("vde_cycles_2frames", 32'(vde_n), 32'd256);
        check("hsync_low_2frames", 32'(hs_n), 32'd72);
        check("vsync_low_2frames", 32'(vs_n), 32'd96);

        for (int i = 0; i < 15; i++) begin
            mode = vecs[i].mode;
            solid_rgb = vecs[i].solid;
            wait_frame_start(ok);
            check($sformatf("vec%0d_frame", i), 32'(ok), 32'd1);
            wait_pixel(vecs[i].px, vecs[i].py, ok);
            check($sformatf("vec%0d_pixel_found", i), 32'(ok), 32'd1);
            want = vecs[i].rgb;
`ifdef VIDEO_BORDER_EN
            if (vecs[i].px == 0 || vecs[i].px == HA - 1 || vecs[i].py == 0 || vecs[i].py == VA - 1)
                want = 24'hFFFFFF;
`endif
            check($sformatf("vec%0d_rgb_m%0d_x%0d_y%0d", i, vecs[i].mode, vecs[i].px, vecs[i].py),
                  {8'h0, R_data, G_data, B_data}, {8'h0, want});
            if (vecs[i].px == HA - 1) begin
                tick();
                check($sformatf("vec%0d_blank_vde", i), 32'(VDE), 32'd0);
                check($sformatf("vec%0d_blank_rgb", i), {8'h0, R_data, G_data, B_data}, 32'd0);
            end
        end

        mode = 2'd0;
        solid_rgb = 24'hA5A5A5;
        wait_frame_start(ok);
        check("switch_frame", 32'(ok), 32'd1);
        wait_pixel(0, 4, ok);
        check("switch_line4_found", 32'(ok), 32'd1);
        mode = 2'd3;
        wait_pixel(14, 6, ok);
        check("switch_tail_found", 32'(ok), 32'd1);
        check("switch_tail_solid", {8'h0, R_data, G_data, B_data}, 32'hA5A5A5);
        wait_frame_start(ok);
        check("grad_frame", 32'(ok), 32'd1);
        wait_pixel(9, 4, ok);
        check("grad_found", 32'(ok), 32'd1);
        check("grad_rgb", {8'h0, R_data, G_data, B_data}, {8'h0, 8'h09, 8'h04, m_fcnt[7:0]});

        wait_frame_start(ok);
        wait_pixel(6, 5, ok);
        check("midreset_found", 32'(ok), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_vde", 32'(VDE), 32'd0);
        check("midreset_cd", 32'(CD), 32'd3);
        check("midreset_rgb", {8'h0, R_data, G_data, B_data}, 32'd0);
        check("midreset_xy", {8'h0, x, y}, 32'd0);
        check("midreset_fs", 32'(frame_start), 32'd0);
        check("midreset_fcnt", 32'(frame_cnt), 32'd0);
        tick();
        check("restart_fs", 32'(frame_start), 32'd1);
        check("restart_fcnt", 32'(frame_cnt), 32'd1);
        check("restart_vde", 32'(VDE), 32'd1);
        for (int i = 0; i < 40; i++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
